ssd_scroll_buffer: RTL

- Upstream feeder for the 8-digit seven-segment driver.
- Accepts hex nibbles from the encryption datapath through a valid/ready handshake and buffers them in a small FIFO.
- Shifts one nibble into a 32-bit display word on each scroll tick, producing a right-to-left marquee.
- The 32-bit output connects directly to the driver's 32-bit display input; digit 0 is bits [3:0] and is the rightmost digit.

---
 rtl/ssd_pkg.sv | 13 +
 rtl/ssd_nib_fifo.sv | 67 ++++++
 rtl/ssd_scroll_buffer.sv | 87 ++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment display datapath.
package ssd_pkg;

   localparam int unsigned SSD_DIGITS           = 8;
   localparam int unsigned SSD_NIB_W            = 4;
   localparam int unsigned SSD_WORD_W           = 32;
   // One scroll step every 250 ms from the 100 MHz board clock
   localparam int unsigned SSD_TICK_DIV_DEFAULT = 25_000_000;

   typedef logic [SSD_NIB_W-1:0]  ssd_nib_t;
   typedef logic [SSD_WORD_W-1:0] ssd_word_t;

endpackage

// File: rtl/ssd_nib_fifo.sv
// DEPTH x 4-bit synchronous FIFO with occupancy counter; flush clears pointers and count.
module ssd_nib_fifo
   import ssd_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     flush,
   input  logic                     push,
   input  ssd_nib_t                 push_data,
   input  logic                     pop,
   output ssd_nib_t                 pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   ssd_nib_t               mem_q [DEPTH];
   ssd_nib_t               mem_d [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
   end

   // Storage is not reset; stale entries are unreachable once pointers clear
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);

endmodule

// File: rtl/ssd_scroll_buffer.sv
// Nibble FIFO feeding a right-to-left marquee word for the 8-digit SSD driver.
// Optional build macro SCROLL_LOOP_EN recirculates popped nibbles back into the FIFO.
module ssd_scroll_buffer
   import ssd_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned TICK_DIV = SSD_TICK_DIV_DEFAULT
) (
   input  logic                     scroll_clk,
   input  logic                     scroll_rst,
   input  logic                     scroll_clr,
   input  logic                     scroll_en,
   input  logic [SSD_NIB_W-1:0]     scroll_in_nib,
   input  logic                     scroll_in_valid,
   output logic                     scroll_in_ready,
   output logic [SSD_WORD_W-1:0]    scroll_out,
   output logic [$clog2(DEPTH):0]   scroll_count,
   output logic                     scroll_full,
   output logic                     scroll_empty
);

   localparam int unsigned TCNT_W = $clog2(TICK_DIV);

   logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
   ssd_word_t             out_q, out_d;
   logic                  flush_c;
   logic                  tick_c;
   logic                  pop_c;
   logic                  push_c;
   logic                  fifo_push_c;
   ssd_nib_t              fifo_wdata_c;
   ssd_nib_t              fifo_rdata_c;

   assign flush_c = scroll_rst | scroll_clr;
   assign tick_c  = scroll_en && (tcnt_q == TCNT_W'(TICK_DIV - 1));
   assign pop_c   = tick_c && !scroll_empty;

`ifdef SCROLL_LOOP_EN
   // The write port is taken by the recirculated nibble on a popping tick
   assign scroll_in_ready = !scroll_full && !pop_c;
   assign push_c          = scroll_in_valid && scroll_in_ready;
   assign fifo_push_c     = push_c || pop_c;
   assign fifo_wdata_c    = pop_c ? fifo_rdata_c : scroll_in_nib;
`else
   assign scroll_in_ready = !scroll_full;
   assign push_c          = scroll_in_valid && scroll_in_ready;
   assign fifo_push_c     = push_c;
   assign fifo_wdata_c    = scroll_in_nib;
`endif

   always_comb begin
      tcnt_d = tcnt_q;
      out_d  = out_q;
      if (scroll_en) begin
         tcnt_d = tick_c ? '0 : tcnt_q + TCNT_W'(1);
      end
      if (pop_c) begin
         out_d = {out_q[SSD_WORD_W-SSD_NIB_W-1:0], fifo_rdata_c};
      end
      if (flush_c) begin
         tcnt_d = '0;
         out_d  = '0;
      end
   end

   always_ff @(posedge scroll_clk) begin
      tcnt_q <= tcnt_d;
      out_q  <= out_d;
   end

   ssd_nib_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (scroll_clk),
      .flush     (flush_c),
      .push      (fifo_push_c),
      .push_data (fifo_wdata_c),
      .pop       (pop_c),
      .pop_data  (fifo_rdata_c),
      .count     (scroll_count),
      .full      (scroll_full),
      .empty     (scroll_empty)
   );

   assign scroll_out = out_q;

endmodule
